// File: rtl/vga_fb_scan_ctrl_pkg.sv
// vga_pkg: 640x480@60 timing constants, framebuffer geometry and pixel type
package vga_pkg;
    localparam int CLK_DIV     = 4;
    localparam int H_ACTIVE    = 640;
    localparam int H_FP        = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BP        = 48;
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE    = 480;
    localparam int V_FP        = 10;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 33;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SCALE_SHIFT = 2;
    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int FB_DEPTH    = FB_W * FB_H;
    localparam int ADDR_W      = 15;
    localparam int CNT_W       = 10;
    typedef logic [11:0] rgb_t;
endpackage

// File: rtl/vga_fb_scan_ctrl_if.sv
// vga_fb_scan_ctrl_if: single framebuffer port plus draw-client write port
// master: the scan controller (drives fb_addr/fb_we/fb_wdata/wr_ack)
// slave:  the RAM and draw client (drive fb_rdata/wr_req/wr_addr/wr_data)
interface vga_fb_scan_ctrl_if;
    import vga_pkg::*;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_we;
    rgb_t              fb_wdata;
    rgb_t              fb_rdata;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    rgb_t              wr_data;
    logic              wr_ack;
    modport master (output fb_addr, fb_we, fb_wdata, wr_ack, input fb_rdata, wr_req, wr_addr, wr_data);
    modport slave (input fb_addr, fb_we, fb_wdata, wr_ack, output fb_rdata, wr_req, wr_addr, wr_data);
endinterface

// File: rtl/vga_fb_scan_ctrl_timing.sv
// vga_timing_gen: pixel clock-enable divider and h/v raster counters
// in:  clk, rst (async, active high)
// out: div, h_cnt, v_cnt, pix_ce, active, vblank, frame_start (registered pulse)
module vga_timing_gen import vga_pkg::*; #(
    parameter int CLK_DIV  = vga_pkg::CLK_DIV,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_TOTAL  = vga_pkg::V_TOTAL,
    localparam int DIV_W   = $clog2(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [DIV_W-1:0] div,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             pix_ce,
    output logic             active,
    output logic             vblank,
    output logic             frame_start
);
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             fs_q, h_wrap, v_wrap;
    assign pix_ce = div_q == DIV_W'(CLK_DIV - 1);
    assign h_wrap = h_q == CNT_W'(H_TOTAL - 1);
    assign v_wrap = v_q == CNT_W'(V_TOTAL - 1);
    always_comb begin
        div_d = pix_ce ? '0 : div_q + 1'b1;
        h_d   = pix_ce ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
        v_d   = (pix_ce && h_wrap) ? (v_wrap ? '0 : v_q + 1'b1) : v_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            fs_q  <= pix_ce && h_wrap && v_wrap;
        end
    end
    assign div         = div_q;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign active      = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
    assign vblank      = v_q >= CNT_W'(V_ACTIVE);
    assign frame_start = fs_q;
endmodule

// File: rtl/vga_fb_scan_ctrl.sv
// vga_fb_scan_ctrl: VGA scan-out with 4x upscaled framebuffer fetch and write-port arbitration
// in:  sys_clk, sys_rst (async, active high)
// out: h_sync, v_sync (active low), pixel_data, vblank, frame_start
// bus: framebuffer port (1-cycle read latency) shared with one draw client
module vga_fb_scan_ctrl import vga_pkg::*; #(
    parameter int CLK_DIV     = vga_pkg::CLK_DIV,
    parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int H_FP        = vga_pkg::H_FP,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_BP        = vga_pkg::H_BP,
    parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int V_FP        = vga_pkg::V_FP,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_BP        = vga_pkg::V_BP,
    parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
    localparam int DIV_W      = $clog2(CLK_DIV)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    output logic                  h_sync,
    output logic                  v_sync,
    output rgb_t                  pixel_data,
    output logic                  vblank,
    output logic                  frame_start,
    vga_fb_scan_ctrl_if.master    bus
);
    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = V_ACTIVE + V_FP + V_SYNC - 1;
    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  h_cnt, v_cnt, x, y;
    logic              pix_ce, active, disp, grant;
    logic [ADDR_W-1:0] disp_addr;
    rgb_t              rgb_q, rgb_d, pix_q, pix_d;
    logic              hs_q, hs_d, vs_q, vs_d;
    vga_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .H_ACTIVE(H_ACTIVE),
        .H_TOTAL (H_ACTIVE + H_FP + H_SYNC + H_BP),
        .V_ACTIVE(V_ACTIVE),
        .V_TOTAL (V_ACTIVE + V_FP + V_SYNC + V_BP)
    ) u_timing (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .div        (div),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .pix_ce     (pix_ce),
        .active     (active),
        .vblank     (vblank),
        .frame_start(frame_start)
    );
    assign x         = h_cnt >> SCALE_SHIFT;
    assign y         = v_cnt >> SCALE_SHIFT;
    // y*160 + x without a multiplier
    assign disp_addr = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    // the first sub-cycle of every visible pixel belongs to the display fetch
    assign disp      = (div == '0) && active;
    assign grant     = !sys_rst && !disp && bus.wr_req;
    always_comb begin
        bus.fb_addr  = disp ? disp_addr : (grant ? bus.wr_addr : '0);
        bus.fb_we    = grant && (bus.wr_addr < ADDR_W'(FB_DEPTH));
        bus.fb_wdata = grant ? bus.wr_data : '0;
        bus.wr_ack   = grant;
        rgb_d        = (div == DIV_W'(1) && active) ? bus.fb_rdata : rgb_q;
        pix_d        = pix_ce ? (active ? rgb_q : '0) : pix_q;
        hs_d         = pix_ce ? !(h_cnt >= CNT_W'(HS_LO) && h_cnt <= CNT_W'(HS_HI)) : hs_q;
        vs_d         = pix_ce ? !(v_cnt >= CNT_W'(VS_LO) && v_cnt <= CNT_W'(VS_HI)) : vs_q;
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rgb_q <= '0;
            pix_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            pix_q <= pix_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
        end
    end
    assign pixel_data = pix_q;
    assign h_sync     = hs_q;
    assign v_sync     = vs_q;
endmodule

// File: tb/tb_vga_fb_scan_ctrl.sv
// tb_vga_fb_scan_ctrl: directed checks of scan timing, pixel fetch, write arbitration and reset
module tb_vga_fb_scan_ctrl;
    import vga_pkg::*;
    logic sys_clk = 1'b0;
    logic sys_rst;
    logic h_sync, v_sync, vblank, frame_start;
    rgb_t pixel_data;
    int   cyc;
    int   vectors = 0;
    int   miscompares = 0;
    rgb_t mem [0:FB_DEPTH-1];

    vga_fb_scan_ctrl_if bus();

    // short vertical timing keeps a whole frame (14 lines) inside the run budget
    vga_fb_scan_ctrl #(
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .pixel_data (pixel_data),
        .vblank     (vblank),
        .frame_start(frame_start),
        .bus        (bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or posedge sys_rst) cyc <= sys_rst ? 0 : cyc + 1;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < FB_DEPTH; i++) mem[i] <= '0;
            mem[0]   <= 12'h111;
            mem[1]   <= 12'hABC;
            mem[159] <= 12'h5A5;
            mem[160] <= 12'h123;
            mem[234] <= 12'h7E7;
            mem[235] <= 12'h7E7;
            mem[319] <= 12'h3C3;
        end else if (bus.fb_we && bus.fb_addr < ADDR_W'(FB_DEPTH)) begin
            mem[bus.fb_addr] <= bus.fb_wdata;
        end
        bus.fb_rdata <= (bus.fb_addr < ADDR_W'(FB_DEPTH)) ? mem[bus.fb_addr] : '0;
    end

    task automatic at(input int n);
        if (cyc > n) begin
            miscompares++;
            $display("FAIL at: cycle %0d already past target %0d", cyc, n);
        end
        while (cyc < n) @(negedge sys_clk);
    endtask

    task automatic test_reset;
        bus.wr_req = 1'b1; bus.wr_addr = 15'd9; bus.wr_data = 12'h777;
        #1;
        vectors++; if (h_sync !== 1'b1) begin miscompares++; $display("FAIL rst_hsync: got %b want 1", h_sync); end
        vectors++; if (v_sync !== 1'b1) begin miscompares++; $display("FAIL rst_vsync: got %b want 1", v_sync); end
        vectors++; if (pixel_data !== 12'h000) begin miscompares++; $display("FAIL rst_pix: got %h want 000", pixel_data); end
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL rst_fs: got %b want 0", frame_start); end
        vectors++; if (bus.wr_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %b want 0", bus.wr_ack); end
        vectors++; if (bus.fb_we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", bus.fb_we); end
        bus.wr_req = 1'b0;
    endtask

    task automatic test_first_pixels;
        at(3);
        vectors++; if (pixel_data !== 12'h000) begin miscompares++; $display("FAIL pix_c3: got %h want 000", pixel_data); end
        at(4);
        vectors++; if (pixel_data !== 12'h111) begin miscompares++; $display("FAIL pix_c4: got %h want 111", pixel_data); end
        at(19);
        vectors++; if (pixel_data !== 12'h111) begin miscompares++; $display("FAIL pix_x3: got %h want 111", pixel_data); end
        at(20);
        vectors++; if (pixel_data !== 12'hABC) begin miscompares++; $display("FAIL pix_x4: got %h want ABC", pixel_data); end
        at(35);
        vectors++; if (pixel_data !== 12'hABC) begin miscompares++; $display("FAIL pix_x7: got %h want ABC", pixel_data); end
        at(36);
        vectors++; if (pixel_data !== 12'h000) begin miscompares++; $display("FAIL pix_x8: got %h want 000", pixel_data); end
    endtask

    task automatic test_contention;
        at(40);
        bus.wr_req = 1'b1; bus.wr_addr = 15'd5; bus.wr_data = 12'hF0F;
        #1;
        vectors++; if (bus.wr_ack !== 1'b0) begin miscompares++; $display("FAIL con_ack0: got %b want 0", bus.wr_ack); end
        vectors++; if (bus.fb_we !== 1'b0) begin miscompares++; $display("FAIL con_we0: got %b want 0", bus.fb_we); end
        vectors++; if (bus.fb_addr !== 15'd2) begin miscompares++; $display("FAIL con_addr0: got %0d want 2", bus.fb_addr); end
        at(41);
        #1;
        vectors++; if (bus.wr_ack !== 1'b1) begin miscompares++; $display("FAIL con_ack1: got %b want 1", bus.wr_ack); end
        vectors++; if (bus.fb_we !== 1'b1) begin miscompares++; $display("FAIL con_we1: got %b want 1", bus.fb_we); end
        vectors++; if (bus.fb_addr !== 15'd5) begin miscompares++; $display("FAIL con_addr1: got %0d want 5", bus.fb_addr); end
        vectors++; if (bus.fb_wdata !== 12'hF0F) begin miscompares++; $display("FAIL con_wdata1: got %h want F0F", bus.fb_wdata); end
        at(42);
        bus.wr_req = 1'b0;
        at(84);
        vectors++; if (pixel_data !== 12'hF0F) begin miscompares++; $display("FAIL con_readback: got %h want F0F", pixel_data); end
    endtask

    task automatic test_line_end;
        at(2560);
        vectors++; if (pixel_data !== 12'h5A5) begin miscompares++; $display("FAIL pix_x639: got %h want 5A5", pixel_data); end
        at(2564);
        vectors++; if (pixel_data !== 12'h000) begin miscompares++; $display("FAIL pix_hblank: got %h want 000", pixel_data); end
    endtask

    task automatic test_hsync;
        at(2627);
        vectors++; if (h_sync !== 1'b1) begin miscompares++; $display("FAIL hs_pre: got %b want 1", h_sync); end
        at(2628);
        vectors++; if (h_sync !== 1'b0) begin miscompares++; $display("FAIL hs_fall: got %b want 0", h_sync); end
        at(3011);
        vectors++; if (h_sync !== 1'b0) begin miscompares++; $display("FAIL hs_last: got %b want 0", h_sync); end
        at(3012);
        vectors++; if (h_sync !== 1'b1) begin miscompares++; $display("FAIL hs_rise: got %b want 1", h_sync); end
        at(5828);
        vectors++; if (h_sync !== 1'b0) begin miscompares++; $display("FAIL hs_period: got %b want 0", h_sync); end
    endtask

    task automatic test_hblank_grant;
        at(6000);
        bus.wr_req = 1'b1; bus.wr_addr = 15'd19200; bus.wr_data = 12'hFFF;
        #1;
        vectors++; if (bus.wr_ack !== 1'b1) begin miscompares++; $display("FAIL oor_ack: got %b want 1", bus.wr_ack); end
        vectors++; if (bus.fb_we !== 1'b0) begin miscompares++; $display("FAIL oor_we: got %b want 0", bus.fb_we); end
        vectors++; if (bus.fb_addr !== 15'd19200) begin miscompares++; $display("FAIL oor_addr: got %0d want 19200", bus.fb_addr); end
        for (int i = 1; i < 3; i++) begin
            at(6000 + i);
            bus.wr_addr = 15'(299 + i); bus.wr_data = 12'(i);
            #1;
            vectors++; if (bus.wr_ack !== 1'b1) begin miscompares++; $display("FAIL hb_ack%0d: got %b want 1", i, bus.wr_ack); end
            vectors++; if (bus.fb_we !== 1'b1) begin miscompares++; $display("FAIL hb_we%0d: got %b want 1", i, bus.fb_we); end
            vectors++; if (bus.fb_addr !== 15'(299 + i)) begin miscompares++; $display("FAIL hb_addr%0d: got %0d want %0d", i, bus.fb_addr, 299 + i); end
        end
        at(6003);
        bus.wr_req = 1'b0;
        #1;
        vectors++; if (bus.fb_addr !== 15'd0) begin miscompares++; $display("FAIL idle_addr: got %0d want 0", bus.fb_addr); end
        vectors++; if (bus.fb_wdata !== 12'h000) begin miscompares++; $display("FAIL idle_wdata: got %h want 000", bus.fb_wdata); end
        vectors++; if (bus.wr_ack !== 1'b0) begin miscompares++; $display("FAIL idle_ack: got %b want 0", bus.wr_ack); end
    endtask

    task automatic test_lines;
        at(9604);
        vectors++; if (pixel_data !== 12'h111) begin miscompares++; $display("FAIL l3x0: got %h want 111", pixel_data); end
        at(12804);
        vectors++; if (pixel_data !== 12'h123) begin miscompares++; $display("FAIL l4x0: got %h want 123", pixel_data); end
        at(12820);
        vectors++; if (pixel_data !== 12'h000) begin miscompares++; $display("FAIL l4x4: got %h want 000", pixel_data); end
        at(22419);
        vectors++; if (pixel_data !== 12'h123) begin miscompares++; $display("FAIL l7x3: got %h want 123", pixel_data); end
    endtask

    task automatic test_vblank;
        at(24960);
        vectors++; if (pixel_data !== 12'h3C3) begin miscompares++; $display("FAIL l7x639: got %h want 3C3", pixel_data); end
        at(24964);
        vectors++; if (pixel_data !== 12'h000) begin miscompares++; $display("FAIL l7hb: got %h want 000", pixel_data); end
        at(25599);
        vectors++; if (vblank !== 1'b0) begin miscompares++; $display("FAIL vb_pre: got %b want 0", vblank); end
        at(25600);
        vectors++; if (vblank !== 1'b1) begin miscompares++; $display("FAIL vb_rise: got %b want 1", vblank); end
        at(25604);
        vectors++; if (pixel_data !== 12'h000) begin miscompares++; $display("FAIL vb_pix: got %h want 000", pixel_data); end
        for (int i = 0; i < 4; i++) begin
            at(25700 + i);
            bus.wr_req = 1'b1; bus.wr_addr = 15'(100 + i); bus.wr_data = 12'(i);
            #1;
            vectors++; if (bus.wr_ack !== 1'b1) begin miscompares++; $display("FAIL vb_ack%0d: got %b want 1", i, bus.wr_ack); end
            vectors++; if (bus.fb_addr !== 15'(100 + i)) begin miscompares++; $display("FAIL vb_addr%0d: got %0d want %0d", i, bus.fb_addr, 100 + i); end
        end
        at(25704);
        bus.wr_req = 1'b0;
    endtask

    task automatic test_vsync;
        at(32003);
        vectors++; if (v_sync !== 1'b1) begin miscompares++; $display("FAIL vs_pre: got %b want 1", v_sync); end
        at(32004);
        vectors++; if (v_sync !== 1'b0) begin miscompares++; $display("FAIL vs_fall: got %b want 0", v_sync); end
        at(38403);
        vectors++; if (v_sync !== 1'b0) begin miscompares++; $display("FAIL vs_last: got %b want 0", v_sync); end
        at(38404);
        vectors++; if (v_sync !== 1'b1) begin miscompares++; $display("FAIL vs_rise: got %b want 1", v_sync); end
    endtask

    task automatic test_frame_start;
        at(44799);
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL fs_pre: got %b want 0", frame_start); end
        at(44800);
        vectors++; if (frame_start !== 1'b1) begin miscompares++; $display("FAIL fs_pulse: got %b want 1", frame_start); end
        vectors++; if (vblank !== 1'b0) begin miscompares++; $display("FAIL fs_vblank: got %b want 0", vblank); end
        at(44801);
        vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL fs_post: got %b want 0", frame_start); end
    endtask

    task automatic test_reset_midline;
        at(62001);
        bus.wr_req = 1'b1; bus.wr_addr = 15'd7; bus.wr_data = 12'h555;
        #1;
        vectors++; if (pixel_data !== 12'h7E7) begin miscompares++; $display("FAIL mid_pix: got %h want 7E7", pixel_data); end
        vectors++; if (bus.wr_ack !== 1'b1) begin miscompares++; $display("FAIL mid_ack: got %b want 1", bus.wr_ack); end
        sys_rst = 1'b1;
        #1;
        vectors++; if (pixel_data !== 12'h000) begin miscompares++; $display("FAIL mid_rst_pix: got %h want 000", pixel_data); end
        vectors++; if (h_sync !== 1'b1) begin miscompares++; $display("FAIL mid_rst_hs: got %b want 1", h_sync); end
        vectors++; if (v_sync !== 1'b1) begin miscompares++; $display("FAIL mid_rst_vs: got %b want 1", v_sync); end
        vectors++; if (bus.wr_ack !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ack: got %b want 0", bus.wr_ack); end
        vectors++; if (bus.fb_we !== 1'b0) begin miscompares++; $display("FAIL mid_rst_we: got %b want 0", bus.fb_we); end
        bus.wr_req = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_restart;
        at(3);
        vectors++; if (pixel_data !== 12'h000) begin miscompares++; $display("FAIL rs_c3: got %h want 000", pixel_data); end
        at(4);
        vectors++; if (pixel_data !== 12'h111) begin miscompares++; $display("FAIL rs_c4: got %h want 111", pixel_data); end
        at(20);
        vectors++; if (pixel_data !== 12'hABC) begin miscompares++; $display("FAIL rs_x4: got %h want ABC", pixel_data); end
        at(2627);
        vectors++; if (h_sync !== 1'b1) begin miscompares++; $display("FAIL rs_hs_pre: got %b want 1", h_sync); end
        at(2628);
        vectors++; if (h_sync !== 1'b0) begin miscompares++; $display("FAIL rs_hs_fall: got %b want 0", h_sync); end
    endtask

    initial begin
        sys_rst = 1'b1;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) @(negedge sys_clk);
        test_reset;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        test_first_pixels;
        test_contention;
        test_line_end;
        test_hsync;
        test_hblank_grant;
        test_lines;
        test_vblank;
        test_vsync;
        test_frame_start;
        test_reset_midline;
        test_restart;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_fb_scan_ctrl.md
Name: vga_fb_scan_ctrl

Overview:
Scan-out controller and framebuffer port arbiter for the 640x480@60 VGA path, run from the 100 MHz system clock with a pixel clock-enable. It generates h_sync/v_sync, fetches 12-bit RGB pixels from a single-port 160x120 framebuffer upscaled 4x, and shares that port with one drawing client. It sits between the framebuffer RAM and the VGA pins inside vga_test_top.

Parameters:
CLK_DIV, 4, sys_clk cycles per pixel; must be >= 2.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch (pixels).
H_SYNC, 96, horizontal sync width (pixels).
H_BP, 48, horizontal back porch; line total 800.
V_ACTIVE, 480, visible lines.
V_FP, 10, vertical front porch (lines).
V_SYNC, 2, vertical sync width (lines).
V_BP, 33, vertical back porch; frame total 525.
SCALE_SHIFT, 2, log2 of upscale factor; framebuffer is 160x120.
ADDR_W, 15, framebuffer address width; 19200 words.

Ports:
sys_clk  in  1  system clock, 100 MHz.
sys_rst  in  1  asynchronous, active-high reset.
h_sync  out  1  horizontal sync, active low, registered.
v_sync  out  1  vertical sync, active low, registered.
pixel_data  out  12  RGB444 output; 0 during blanking; registered.
vblank  out  1  high while v_cnt >= V_ACTIVE.
frame_start  out  1  one-cycle pulse at frame wrap.
fb_addr  out  ADDR_W  framebuffer address.
fb_we  out  1  framebuffer write enable.
fb_wdata  out  12  framebuffer write data.
fb_rdata  in  12  framebuffer read data; 1 sys_clk latency.
wr_req  in  1  draw-client write request; addr and data held until ack.
wr_addr  in  ADDR_W  draw-client target address.
wr_data  in  12  draw-client pixel.
wr_ack  out  1  grant; the write occurs in the same cycle.

Behaviour:
- Reset (async): div=0, h_cnt=0, v_cnt=0, h_sync=1, v_sync=1, pixel_data=0, frame_start=0, internal rgb latch=0. While reset is asserted: wr_ack=0 and fb_we=0.
- The reset clock/reset names and polarity are fixed: sys_clk, sys_rst, asynchronous, active-high.
- Divider: div counts 0..CLK_DIV-1. pix_ce is asserted when div==CLK_DIV-1.
- Counters:
  - On pix_ce, h_cnt increments and wraps 799->0.
  - On the h_cnt wrap, v_cnt increments and wraps 524->0.
  - frame_start pulses on the pix_ce where both counters wrap.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Display slot: div==0 && active.
  - fb_addr = (v_cnt>>2)*160 + (h_cnt>>2), computed as (y<<7)+(y<<5)+x in ADDR_W bits. fb_we=0.
  - At div==1, fb_rdata is latched into rgb.
- Output register (on pix_ce), using the current h_cnt/v_cnt:
  - pixel_data <= active ? rgb : 0.
  - h_sync <= !(656 <= h_cnt <= 751).
  - v_sync <= !(490 <= v_cnt <= 491).
  - All outputs therefore lag the counters by exactly one pixel period and stay mutually aligned.
- Write grant: in every cycle that is not a display slot, wr_ack = wr_req, fb_addr = wr_addr, fb_wdata = wr_data.
  - fb_we = wr_req && (wr_addr < 19200).
  - An out-of-range address is still acked, but the write is dropped.
- Contention: the display slot always wins. A pending wr_req in a display slot gets wr_ack=0 and is served at div==1 of the same pixel.
  - During active video a writer gets at most CLK_DIV-1 grants per pixel.
  - During blanking it gets a grant every cycle.
- Idle: when there is no display slot and no wr_req, fb_addr=0, fb_we=0, fb_wdata=0.
- Reset mid-frame: everything restarts from (0,0), div=0. A write in progress is not acked; the client must re-present it.

Decomposition:
- Package vga_pkg holds:
  - timing constants (H_ACTIVE, H_FP, H_SYNC, H_BP, V_*, H_TOTAL=800, V_TOTAL=525);
  - FB_W=160, FB_H=120, FB_DEPTH=19200, ADDR_W=15;
  - rgb_t (12-bit) typedef.
- One sub-module, vga_timing_gen: divider, h/v counters, pix_ce, active, vblank, frame_start.
- Address generation, arbitration and output registers stay in vga_fb_scan_ctrl.

Test Plan:
- Release reset, no writes -> first pix_ce at cycle 3 after release. h_sync period is 3200 cycles with a 384-cycle low; v_sync low for 6400 cycles; frame_start period is 1,680,000 cycles.
- Preload fb[1]=12'hABC and fb[160]=12'h123, then scan out:
  - pixel_data=12'hABC for output pixels x=4..7 of line 0;
  - pixel_data=12'h123 for x=0..3 of lines 4..7;
  - pixel_data=0 for h_cnt >= 640 and for v_cnt >= 480.
- During active video, hold wr_req=1 (addr=5, data=12'hF0F) entering div==0 -> wr_ack=0 at div 0; wr_ack=1 and fb_we=1 at div 1, with fb_addr=5 at div 1.
- During vblank, wr_req held continuously -> wr_ack=1 every cycle and fb_addr follows wr_addr each cycle.
- wr_req with wr_addr=19200 -> wr_ack=1, fb_we=0, RAM unchanged.
- Assert sys_rst asynchronously mid-line at h_cnt=300, v_cnt=200 -> outputs immediately become h_sync=1, v_sync=1, pixel_data=0, wr_ack=0. After release, counting restarts from (0,0).
